// File: rtl/ex_alu_unit_if.sv
// Handshake and data bundle between the issue stage, ex_alu_unit and the write-back consumer.
// Ports: request side i_valid/o_ready with i_alu_ctrl, i_a, i_b, i_shamt;
//        response side o_valid/i_ready with o_result, o_zero, o_illegal, o_overflow.
// slave modport is the ALU's view; master modport is the driver/consumer view.
interface ex_alu_unit_if #(
  parameter int DATA_W = 32
);
  logic              i_valid;
  logic              o_ready;
  logic [5:0]        i_alu_ctrl;
  logic [DATA_W-1:0] i_a;
  logic [DATA_W-1:0] i_b;
  logic [4:0]        i_shamt;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_result;
  logic              o_zero;
  logic              o_illegal;
  logic              o_overflow;

  modport slave (
    input  i_valid, i_alu_ctrl, i_a, i_b, i_shamt, i_ready,
    output o_ready, o_valid, o_result, o_zero, o_illegal, o_overflow
  );

  modport master (
    output i_valid, i_alu_ctrl, i_a, i_b, i_shamt, i_ready,
    input  o_ready, o_valid, o_result, o_zero, o_illegal, o_overflow
  );
endinterface

// File: rtl/ex_alu_unit.sv
// Execute-stage ALU: logic/arith/compare ops plus an iterative shifter, SHIFT_STEP bits per cycle.
// Latency: 1 cycle for non-shift ops; ceil(n/SHIFT_STEP) cycles (min 1) for a shift by n.
// Backpressure: o_ready low while shifting or while a result waits for i_ready; back-to-back accept on consume.
// Ports: i_clk, i_rst_n (async active-low), bus (ex_alu_unit_if.slave, request + response handshakes).
// Optional: define ALU_OVERFLOW_TRAP_EN to register signed overflow of ADD/SUB on o_overflow.
module ex_alu_unit #(
  parameter int DATA_W     = 32,
  parameter int SHIFT_STEP = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  ex_alu_unit_if.slave  bus
);

  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_ADDU = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_SUBU = 6'd45;
  localparam logic [5:0] OP_AND  = 6'd18;
  localparam logic [5:0] OP_OR   = 6'd19;
  localparam logic [5:0] OP_NOR  = 6'd20;
  localparam logic [5:0] OP_XOR  = 6'd21;
  localparam logic [5:0] OP_LUI  = 6'd17;
  localparam logic [5:0] OP_SLT  = 6'd30;
  localparam logic [5:0] OP_SLTU = 6'd31;
  localparam logic [5:0] OP_BEQ  = 6'd9;
  localparam logic [5:0] OP_BNE  = 6'd10;
  localparam logic [5:0] OP_JUMP = 6'd14;
  localparam logic [5:0] OP_SLL  = 6'd23;
  localparam logic [5:0] OP_SRL  = 6'd24;
  localparam logic [5:0] OP_SRA  = 6'd28;
  localparam logic [5:0] OP_SLLV = 6'd36;
  localparam logic [5:0] OP_SRLV = 6'd37;
  localparam logic [5:0] OP_SRAV = 6'd15;

  // Six bits so that a SHIFT_STEP of 32 is representable.
  localparam logic [5:0] STEP_AMT = 6'(SHIFT_STEP);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  typedef enum logic [1:0] {SK_LL, SK_RL, SK_RA} shk_t;

  state_t            state_q;
  logic [DATA_W-1:0] res_q;
  logic              zero_q;
  logic              ill_q;
  logic [DATA_W-1:0] shv_q;   // partially shifted operand
  logic [5:0]        rem_q;   // bits still to shift
  shk_t              kind_q;

  logic              accept;
  logic [DATA_W-1:0] sum, diff;
  logic [DATA_W-1:0] res_d;
  logic              zero_d, ill_d, is_shift;
  shk_t              kind_d;
  logic [5:0]        amt_d, first_k, first_rem, step_k, step_rem;
  logic [DATA_W-1:0] first_val, step_val;

  function automatic logic [DATA_W-1:0] shift_by(input logic [DATA_W-1:0] v, input shk_t kind,
                                                 input logic [5:0] k);
    case (kind)
      SK_RL:   return v >> k;
      SK_RA:   return DATA_W'($signed(v) >>> k);
      default: return v << k;
    endcase
  endfunction

  function automatic logic [5:0] step_of(input logic [5:0] rem);
    return (rem > STEP_AMT) ? STEP_AMT : rem;
  endfunction

  assign bus.o_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.i_ready);
  assign accept      = bus.i_valid && bus.o_ready;
  assign bus.o_valid = (state_q == S_DONE);
  assign bus.o_result  = res_q;
  assign bus.o_zero    = zero_q;
  assign bus.o_illegal = ill_q;

  assign sum  = bus.i_a + bus.i_b;
  assign diff = bus.i_a - bus.i_b;

  // Decode of the operation being presented; only consumed on accept.
  always_comb begin
    res_d    = '0;
    zero_d   = 1'b0;
    ill_d    = 1'b0;
    is_shift = 1'b0;
    kind_d   = SK_LL;
    amt_d    = 6'd0;
    case (bus.i_alu_ctrl)
      OP_ADD, OP_ADDU: res_d = sum;
      OP_SUB, OP_SUBU: res_d = diff;
      OP_AND:  res_d = bus.i_a & bus.i_b;
      OP_OR:   res_d = bus.i_a | bus.i_b;
      OP_NOR:  res_d = ~(bus.i_a | bus.i_b);
      OP_XOR:  res_d = bus.i_a ^ bus.i_b;
      OP_LUI:  res_d = {bus.i_b[15:0], 16'h0000};
      OP_SLT:  res_d = {{(DATA_W-1){1'b0}}, ($signed(bus.i_a) < $signed(bus.i_b))};
      OP_SLTU: res_d = {{(DATA_W-1){1'b0}}, (bus.i_a < bus.i_b)};
      OP_BEQ: begin
        res_d  = diff;
        zero_d = (bus.i_a == bus.i_b);
      end
      OP_BNE: begin
        res_d  = diff;
        zero_d = (bus.i_a != bus.i_b);
      end
      OP_JUMP: res_d = bus.i_a;
      OP_SLL:  begin is_shift = 1'b1; kind_d = SK_LL; amt_d = {1'b0, bus.i_shamt}; end
      OP_SRL:  begin is_shift = 1'b1; kind_d = SK_RL; amt_d = {1'b0, bus.i_shamt}; end
      OP_SRA:  begin is_shift = 1'b1; kind_d = SK_RA; amt_d = {1'b0, bus.i_shamt}; end
      OP_SLLV: begin is_shift = 1'b1; kind_d = SK_LL; amt_d = {1'b0, bus.i_a[4:0]}; end
      OP_SRLV: begin is_shift = 1'b1; kind_d = SK_RL; amt_d = {1'b0, bus.i_a[4:0]}; end
      OP_SRAV: begin is_shift = 1'b1; kind_d = SK_RA; amt_d = {1'b0, bus.i_a[4:0]}; end
      default: ill_d = 1'b1;
    endcase
    // The accept edge already performs the first shift step, which is what
    // makes a shift by n complete in ceil(n/SHIFT_STEP) cycles.
    first_k   = step_of(amt_d);
    first_rem = amt_d - first_k;
    first_val = shift_by(bus.i_b, kind_d, first_k);
    if (is_shift) res_d = first_val;
    step_k   = step_of(rem_q);
    step_rem = rem_q - step_k;
    step_val = shift_by(shv_q, kind_q, step_k);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
      shv_q   <= '0;
      rem_q   <= 6'd0;
      kind_q  <= SK_LL;
    end else if (accept) begin
      if (is_shift && (first_rem != 6'd0)) begin
        state_q <= S_SHIFT;
        shv_q   <= first_val;
        rem_q   <= first_rem;
        kind_q  <= kind_d;
        zero_q  <= 1'b0;
        ill_q   <= 1'b0;
      end else begin
        state_q <= S_DONE;
        res_q   <= res_d;
        zero_q  <= zero_d;
        ill_q   <= ill_d;
      end
    end else begin
      case (state_q)
        S_SHIFT: begin
          shv_q <= step_val;
          rem_q <= step_rem;
          if (step_rem == 6'd0) begin
            state_q <= S_DONE;
            res_q   <= step_val;
          end
        end
        S_DONE: begin
          if (bus.i_ready) begin
            state_q <= S_IDLE;
            zero_q  <= 1'b0;
            ill_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_OVERFLOW_TRAP_EN
  logic ovf_q, ovf_d;

  // Only the trapping forms flag overflow; ADDU/SUBU wrap silently.
  always_comb begin
    ovf_d = 1'b0;
    if (bus.i_alu_ctrl == OP_ADD)
      ovf_d = (bus.i_a[DATA_W-1] == bus.i_b[DATA_W-1]) && (sum[DATA_W-1] != bus.i_a[DATA_W-1]);
    else if (bus.i_alu_ctrl == OP_SUB)
      ovf_d = (bus.i_a[DATA_W-1] != bus.i_b[DATA_W-1]) && (diff[DATA_W-1] != bus.i_a[DATA_W-1]);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      ovf_q <= 1'b0;
    else if (accept)
      ovf_q <= ovf_d;
    else if ((state_q == S_DONE) && bus.i_ready)
      ovf_q <= 1'b0;
  end

  assign bus.o_overflow = ovf_q;
`else
  assign bus.o_overflow = 1'b0;
`endif

endmodule

// File: doc/ex_alu_unit.md
Name: ex_alu_unit

Overview:
- Execute-stage ALU that consumes the 6-bit ALU control code produced by the ALU control decoder, together with the operands and the shift amount.
- Produces a registered result, a zero/branch flag and an illegal-code flag behind a valid/ready handshake on both sides.
- Logic, arithmetic and compare ops complete in 1 cycle.
- Shifts run on an iterative shifter, SHIFT_STEP bits per cycle, so the stage can stall the pipeline through the handshake.

Parameters:
- DATA_W, 32, operand/result width; fixed at 32 for MIPS, other values are unsupported.
- SHIFT_STEP, 4, max bits shifted per iterative cycle; must be a power of 2, from 1 to 32.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  operation presented.
- o_ready  out  1  unit can accept an operation this cycle.
- i_alu_ctrl  in  6  ALU control code.
- i_a  in  DATA_W  operand A (rs).
- i_b  in  DATA_W  operand B (rt or extended immediate).
- i_shamt  in  5  instruction shamt field.
- o_valid  out  1  result available.
- i_ready  in  1  consumer accepts the result.
- o_result  out  DATA_W  result.
- o_zero  out  1  compare/branch flag.
- o_illegal  out  1  control code is not in the supported set.
- o_overflow  out  1  signed overflow; only driven when the optional feature is compiled in.

Behaviour:
- Reset (async, i_rst_n low):
  - state=IDLE.
  - o_valid=0, o_result=0, o_zero=0, o_illegal=0, o_overflow=0.
  - o_ready=1 once reset deasserts.
  - Reset mid-shift abandons the operation; no result is produced.
- States: IDLE, SHIFT, DONE.
- o_ready = (state==IDLE) | (state==DONE & i_ready).
- Accept = i_valid & o_ready. Operands are captured on accept; later changes to the inputs are ignored.
- Codes and ops:
  - ADD 0, ADDU 1: A+B.
  - SUB 2, SUBU 45: A-B.
  - AND 18: A&B.
  - OR 19: A|B.
  - NOR 20: ~(A|B).
  - XOR 21: A^B.
  - LUI 17: {B[15:0],16'h0}.
  - SLT 30: signed A<B gives 1, else 0.
  - SLTU 31: unsigned A<B gives 1, else 0.
  - BEQ 9: result A-B, o_zero=(A==B).
  - BNE 10: result A-B, o_zero=(A!=B).
  - JUMP 14: result=A.
  - SLL 23, SRL 24, SRA 28: shift B by shamt.
  - SLLV 36, SRLV 37, SRAV 15: shift B by A[4:0].
- Any other code: result 0, o_zero=0, o_illegal=1; completes in 1 cycle.
- o_zero is 0 for every non-branch code.
- All arithmetic is modulo 2^32. ADD/ADDU and SUB/SUBU give identical results.
- Non-shift op: accept → DONE on the next edge, with o_valid=1 and outputs registered. Latency is 1 cycle.
- Shift op with amount n:
  - n=0: behaves as a non-shift op; result=B, latency 1.
  - n>0: accept → SHIFT.
  - Each cycle in SHIFT moves min(remaining, SHIFT_STEP) bits. SRA/SRAV fill with B[31]; the others fill with 0.
  - When remaining reaches 0 → DONE.
  - Latency = 1 + ceil(n/SHIFT_STEP) - 1 = ceil(n/SHIFT_STEP) cycles from accept to o_valid. Minimum is 1.
- DONE:
  - o_valid and all outputs are held stable while i_ready=0.
  - On i_ready=1 without a new accept → IDLE, o_valid=0 on the next edge.
  - On i_ready=1 with a simultaneous accept, the result is consumed and the new op starts the same edge (back-to-back, no bubble).
- o_ready=0 in SHIFT. i_valid held during SHIFT is not accepted.
- o_illegal and o_overflow are valid only while o_valid=1, and clear when leaving DONE.

Optional Feature:
- Macro ALU_OVERFLOW_TRAP_EN.
- Defined:
  - For ADD and SUB only (not ADDU/SUBU), o_overflow is registered as the signed overflow of the operation.
  - ADD overflow: operand signs are equal and the result sign differs.
  - SUB overflow: operand signs differ and the result sign differs from A.
  - o_result still carries the wrapped value; the consumer suppresses the write-back.
- Undefined: o_overflow is tied to 0 and no overflow logic is present.

Test Plan:
- Reset then ADD (ctrl 0): A=0x00000005, B=0x00000003 → o_valid 1 cycle after accept, result 0x00000008, o_zero=0. Then SUBU (45) 3-5 → 0xFFFFFFFE.
- SLT/SLTU (30/31) with A=0xFFFFFFFF, B=0x00000001 → SLT 1, SLTU 0. BEQ (9) with A=B=0x1234 → o_zero=1, result 0. BNE (10) with the same operands → o_zero=0.
- SRA (28), B=0x80000000, shamt=31, SHIFT_STEP=4 → o_ready low during SHIFT, o_valid after 8 cycles, result 0xFFFFFFFF. SRLV (37) with A=0, B=0xABCD → latency 1, result 0xABCD.
- Backpressure: i_ready=0 for 5 cycles after OR (19) 0xF0|0x0F → o_result 0x000000FF held stable, o_ready=0. i_ready=1 with i_valid=1 for XOR (21) → next op accepted that edge, with no idle cycle.
- Illegal code 6'd63 → o_illegal=1, result 0. Assert i_rst_n low mid-SLL (shamt 20) → o_valid=0 immediately, and no result is delivered after release.
- With ALU_OVERFLOW_TRAP_EN: ADD 0x7FFFFFFF+1 → result 0x80000000, o_overflow=1. ADDU with the same operands → o_overflow=0.
